apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB requester for the A-side clock domain, sitting directly upstream of the asynchronous bridge and driving its `a_*` APB slave port. It accepts single read/write commands through a valid/ready handshake and sequences the APB SETUP and ACCESS phases. It returns one response per command through a second valid/ready handshake, and aborts any transfer that exceeds a programmable wait-state limit.

## Interface
- `ADDR_WD`, 8: APB address width.
- `DATA_WD`, 32: read/write data width.
- `STRB_WD`, 2: write strobe width.
- `PROT_WD`, 4: protection field width.
- `TIMEOUT`, 16: maximum ACCESS-phase wait edges. 0 disables the timeout. Any other value must be ≥ 2.
- `a_pclk` input 1: the block's one clock.
- `a_prst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when high together with `cmd_valid`.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input ADDR_WD: transfer address.
- `cmd_wdata` input DATA_WD: write data.
- `cmd_strb` input STRB_WD: write strobes.
- `cmd_prot` input PROT_WD: protection.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` output DATA_WD: read data. Always 0 for writes and for timed-out transfers.
- `rsp_timeout` output 1: the transfer was aborted by the timeout.
- `a_psel`, `a_penable`, `a_pwrite` output 1: APB control.
- `a_paddr` output ADDR_WD: APB address.
- `a_pwdata` output DATA_WD: APB write data.
- `a_pprot` output PROT_WD: APB protection.
- `a_pstrb` output STRB_WD: APB write strobes.
- `a_prdata` input DATA_WD: APB read data from the bridge.
- `a_pready` input 1: APB ready from the bridge.

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS. Every output is registered except `cmd_ready`.
- `cmd_ready` = (state == IDLE) && !`rsp_valid`. It is combinational from state and is never dependent on `cmd_valid`.
- IDLE → SETUP on handshake. On that edge the block latches write, addr, wdata, strb and prot onto the `a_*` outputs, and sets `a_psel`=1, `a_penable`=0.
- SETUP → ACCESS unconditionally after one cycle, setting `a_penable`=1.
- In ACCESS, the `a_*` address, data and control outputs stay stable until the phase ends.
- ACCESS with `a_pready`=1 → IDLE:
  - `a_psel`, `a_penable`, `a_pwrite`, `a_paddr`, `a_pwdata`, `a_pprot` and `a_pstrb` return to 0.
  - `rsp_valid`=1 and `rsp_timeout`=0.
  - `rsp_rdata` = `a_prdata` for a read, 0 for a write.
- Wait counter:
  - Cleared on entry to ACCESS.
  - Increments on each ACCESS edge where `a_pready`=0.
  - Sized to hold TIMEOUT; it saturates, so it never wraps.
- Timeout: when the counter equals TIMEOUT−1 and `a_pready`=0 at an ACCESS edge (the TIMEOUT-th wait edge), the FSM goes to IDLE. The APB outputs return to 0, and the response is `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- `a_pready`=1 on that same edge wins: the transfer completes normally.
- Response hold: `rsp_valid`, `rsp_rdata` and `rsp_timeout` hold until `rsp_valid`&&`rsp_ready`. On that edge `rsp_valid`=0; `rsp_rdata` and `rsp_timeout` clear to 0.
- While the response is unconsumed, no new command is accepted. This guarantees at most one outstanding transfer.
- `a_pready` and `a_prdata` are ignored outside ACCESS.

## Timing
- Reset value of every output is 0: `cmd_ready`, `rsp_valid`, `rsp_rdata`, `rsp_timeout` and all `a_*` outputs. The FSM resets to IDLE and the counter to 0.
- Reset acts immediately and asynchronously:
  - `a_psel`/`a_penable` drop without completing the phase.
  - Any pending response is discarded.
- Let edge E be the command handshake:
  - `a_psel`=1 in cycle E+1 (SETUP).
  - `a_penable`=1 in cycle E+2 (ACCESS).
  - With zero wait states, `a_pready` is sampled at edge E+3 and `rsp_valid`=1 in cycle E+3.
  - Minimum latency from command to response is 3 edges. Each wait state adds one edge.
- Timeout with TIMEOUT=N: `rsp_valid` rises after edge E+2+N with `rsp_timeout`=1.
- Back-to-back: response consumed at edge R → `cmd_ready`=1 in cycle R+1 → next SETUP at the earliest in cycle R+2. The APB bus is idle for at least one cycle between transfers.
- A command offered while `cmd_ready`=0 stays pending; the requester must hold it stable until accepted.

## Test plan
- Reset then idle: hold `a_prst_n`=0 → every output 0. Release reset with `cmd_valid`=0 → `cmd_ready`=1 and `a_psel`=0 indefinitely.
- Zero-wait write: addr 0x3F, wdata 0x0000FFFF, strb 2'b11, `a_pready` tied high → SETUP then ACCESS one cycle each. Response after 3 edges with `rsp_timeout`=0 and `rsp_rdata`=0.
- Wait-stated read: addr 0x7F, `a_pready` low for 5 ACCESS edges, then high with `a_prdata`=0xFFFF0000 → `a_paddr` stable for 7 cycles. `rsp_rdata`=0xFFFF0000, latency 8 edges.
- Timeout: TIMEOUT=16, `a_pready` held low → abort after 16 wait edges. `rsp_timeout`=1, `rsp_rdata`=0, `a_psel`=0.
  - Repeat with `a_pready` rising on exactly the 16th wait edge → normal completion with `rsp_timeout`=0.
- Response backpressure: `rsp_ready`=0 for 10 cycles with `cmd_valid` held → `cmd_ready`=0 and no new SETUP for the whole interval. Response fields stay stable throughout. Next transfer starts 2 cycles after the consume edge.
- Reset mid-ACCESS: assert `a_prst_n`=0 during a wait-stated read → `a_psel`, `a_penable` and `rsp_valid` are 0 immediately. After release, `cmd_ready`=1 and no stale response appears.

Source files
------------

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB requester for the A-side clock domain. Single read/write commands come
// in over a valid/ready handshake. The block runs the APB SETUP and ACCESS
// phases on the a_* port. It hands back exactly one response per command over
// a second valid/ready handshake. A transfer that waits longer than TIMEOUT
// ACCESS edges is aborted and reported with rsp_timeout.
//
// Parameters
//   ADDR_WD, DATA_WD, STRB_WD, PROT_WD : APB field widths
//   TIMEOUT : maximum ACCESS wait edges (0 disables, otherwise >= 2)
//
// Ports
//   a_pclk, a_prst_n           : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      : command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot : command fields
//   rsp_valid / rsp_ready      : response handshake
//   rsp_rdata, rsp_timeout     : response fields
//   a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pprot, a_pstrb
//                              : APB request outputs (registered)
//   a_prdata, a_pready         : APB completion inputs from the bridge
// ---------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 2,
  parameter int PROT_WD = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               a_pclk,
  input  logic               a_prst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  input  logic [PROT_WD-1:0] cmd_prot,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_timeout,
  output logic               a_psel,
  output logic               a_penable,
  output logic               a_pwrite,
  output logic [ADDR_WD-1:0] a_paddr,
  output logic [DATA_WD-1:0] a_pwdata,
  output logic [PROT_WD-1:0] a_pprot,
  output logic [STRB_WD-1:0] a_pstrb,
  input  logic [DATA_WD-1:0] a_prdata,
  input  logic               a_pready
);

  // The wait counter must be able to hold TIMEOUT itself. A disabled timeout
  // still needs a legal one-bit vector.
  localparam int CNT_WD = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state;
  logic [CNT_WD-1:0] wait_cnt;
  logic              run;
  logic              timeout_hit;

  // run goes high on the first edge after reset is released. Gating
  // cmd_ready with it keeps cmd_ready low while reset is asserted, even
  // though the state is already IDLE.
  assign cmd_ready = run && (state == IDLE) && !rsp_valid;

  // Abort on the TIMEOUT-th wait edge. A completing a_pready on that same
  // edge takes priority in the FSM below.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST) && !a_pready;

  // Single FSM. It sequences SETUP/ACCESS, owns every registered output,
  // and holds the response until it has been consumed.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      run         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      a_psel      <= 1'b0;
      a_penable   <= 1'b0;
      a_pwrite    <= 1'b0;
      a_paddr     <= '0;
      a_pwdata    <= '0;
      a_pprot     <= '0;
      a_pstrb     <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
          end
          if (cmd_valid && cmd_ready) begin
            a_psel    <= 1'b1;
            a_penable <= 1'b0;
            a_pwrite  <= cmd_write;
            a_paddr   <= cmd_addr;
            a_pwdata  <= cmd_wdata;
            a_pprot   <= cmd_prot;
            a_pstrb   <= cmd_strb;
            state     <= SETUP;
          end
        end

        SETUP: begin
          a_penable <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (a_pready || timeout_hit) begin
            a_psel      <= 1'b0;
            a_penable   <= 1'b0;
            a_pwrite    <= 1'b0;
            a_paddr     <= '0;
            a_pwdata    <= '0;
            a_pprot     <= '0;
            a_pstrb     <= '0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= !a_pready;
            rsp_rdata   <= (a_pready && !a_pwrite) ? a_prdata : '0;
            state       <= IDLE;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_WD'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Directed self-checking bench for apb_cmd_master (TIMEOUT = 16). It covers:
//   - reset and idle behaviour
//   - a zero-wait write
//   - a wait-stated read
//   - a timeout abort, plus a completion on the timeout edge itself
//   - response backpressure
//   - reset applied in the middle of ACCESS
// Inputs change 1 time unit after the rising edge. Outputs are sampled at
// that same point.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

  logic        a_pclk;
  logic        a_prst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [1:0]  cmd_strb;
  logic [3:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        a_psel;
  logic        a_penable;
  logic        a_pwrite;
  logic [7:0]  a_paddr;
  logic [31:0] a_pwdata;
  logic [3:0]  a_pprot;
  logic [1:0]  a_pstrb;
  logic [31:0] a_prdata;
  logic        a_pready;

  int errors = 0;
  int checks = 0;

  apb_cmd_master #(
    .ADDR_WD(8),
    .DATA_WD(32),
    .STRB_WD(2),
    .PROT_WD(4),
    .TIMEOUT(16)
  ) dut (
    .a_pclk     (a_pclk),
    .a_prst_n   (a_prst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .cmd_prot   (cmd_prot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .a_psel     (a_psel),
    .a_penable  (a_penable),
    .a_pwrite   (a_pwrite),
    .a_paddr    (a_paddr),
    .a_pwdata   (a_pwdata),
    .a_pprot    (a_pprot),
    .a_pstrb    (a_pstrb),
    .a_prdata   (a_prdata),
    .a_pready   (a_pready)
  );

  initial a_pclk = 1'b0;
  always #5 a_pclk = ~a_pclk;

  // Advance one clock edge and settle just past it.
  task automatic step();
    @(posedge a_pclk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a command and hold it until the caller drops cmd_valid.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [1:0] strb,
                               input logic [3:0] prot);
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    cmd_valid = 1'b1;
  endtask

  // Consume the pending response and check that the response fields clear.
  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput({tag, "_rsp_valid_cleared"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    a_prst_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    a_prdata  = '0;
    a_pready  = 1'b0;

    // ---- Reset, then idle ----
    step();
    step();
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rst_psel", 32'(a_psel), 32'd0);
    checkOutput("rst_penable", 32'(a_penable), 32'd0);
    checkOutput("rst_pwrite", 32'(a_pwrite), 32'd0);
    checkOutput("rst_paddr", 32'(a_paddr), 32'd0);
    checkOutput("rst_pwdata", a_pwdata, 32'd0);
    checkOutput("rst_pprot", 32'(a_pprot), 32'd0);
    checkOutput("rst_pstrb", 32'(a_pstrb), 32'd0);
    a_prst_n = 1'b1;
    step();
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("idle_psel", 32'(a_psel), 32'd0);
      checkOutput("idle_cmd_ready_hold", 32'(cmd_ready), 32'd1);
    end

    // ---- Zero-wait write ----
    a_pready = 1'b1;
    a_prdata = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 8'h3F, 32'h0000_FFFF, 2'b11, 4'h2);
    step();
    cmd_valid = 1'b0;
    checkOutput("wr_setup_psel", 32'(a_psel), 32'd1);
    checkOutput("wr_setup_penable", 32'(a_penable), 32'd0);
    checkOutput("wr_setup_pwrite", 32'(a_pwrite), 32'd1);
    checkOutput("wr_setup_paddr", 32'(a_paddr), 32'h3F);
    checkOutput("wr_setup_pwdata", a_pwdata, 32'h0000_FFFF);
    checkOutput("wr_setup_pstrb", 32'(a_pstrb), 32'h3);
    checkOutput("wr_setup_pprot", 32'(a_pprot), 32'h2);
    checkOutput("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    checkOutput("wr_access_penable", 32'(a_penable), 32'd1);
    checkOutput("wr_access_psel", 32'(a_psel), 32'd1);
    checkOutput("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("wr_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("wr_done_psel", 32'(a_psel), 32'd0);
    checkOutput("wr_done_penable", 32'(a_penable), 32'd0);
    checkOutput("wr_done_paddr", 32'(a_paddr), 32'd0);
    checkOutput("wr_done_pwdata", a_pwdata, 32'd0);
    checkOutput("wr_done_pwrite", 32'(a_pwrite), 32'd0);
    checkOutput("wr_done_cmd_ready", 32'(cmd_ready), 32'd0);
    consume("wr");

    // ---- Wait-stated read: 5 wait edges ----
    a_pready = 1'b0;
    a_prdata = 32'hFFFF_0000;
    applyStimulus(1'b0, 8'h7F, 32'h1234_5678, 2'b00, 4'h1);
    step();
    cmd_valid = 1'b0;
    checkOutput("rd_setup_paddr", 32'(a_paddr), 32'h7F);
    checkOutput("rd_setup_pwrite", 32'(a_pwrite), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("rd_access_paddr", 32'(a_paddr), 32'h7F);
      checkOutput("rd_access_penable", 32'(a_penable), 32'd1);
      checkOutput("rd_access_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    a_pready = 1'b1;
    step();
    a_pready = 1'b0;
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'hFFFF_0000);
    checkOutput("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rd_done_psel", 32'(a_psel), 32'd0);
    consume("rd");

    // ---- Timeout: a_pready held low ----
    a_prdata = 32'hCAFE_F00D;
    applyStimulus(1'b0, 8'h10, 32'h0, 2'b00, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("to_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("to_wait_psel", 32'(a_psel), 32'd1);
    end
    step();
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("to_psel", 32'(a_psel), 32'd0);
    checkOutput("to_penable", 32'(a_penable), 32'd0);
    consume("to");
    checkOutput("to_timeout_cleared", 32'(rsp_timeout), 32'd0);

    // ---- a_pready rises on exactly the 16th wait edge ----
    applyStimulus(1'b0, 8'h11, 32'h0, 2'b00, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
    end
    checkOutput("tw_still_waiting", 32'(rsp_valid), 32'd0);
    a_pready = 1'b1;
    step();
    a_pready = 1'b0;
    checkOutput("tw_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("tw_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("tw_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    consume("tw");

    // ---- Response backpressure ----
    a_pready = 1'b1;
    a_prdata = 32'hA5A5_5A5A;
    applyStimulus(1'b0, 8'h22, 32'h0, 2'b00, 4'h0);
    step();
    step();
    applyStimulus(1'b0, 8'h55, 32'h0, 2'b00, 4'h3);
    step();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    a_prdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_psel", 32'(a_psel), 32'd0);
      checkOutput("bp_rsp_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata_hold", rsp_rdata, 32'hA5A5_5A5A);
      checkOutput("bp_rsp_timeout_hold", 32'(rsp_timeout), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp_consume_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_consume_rdata", rsp_rdata, 32'd0);
    checkOutput("bp_consume_psel", 32'(a_psel), 32'd0);
    checkOutput("bp_consume_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    checkOutput("bp_next_psel", 32'(a_psel), 32'd1);
    checkOutput("bp_next_paddr", 32'(a_paddr), 32'h55);
    checkOutput("bp_next_pprot", 32'(a_pprot), 32'h3);
    step();
    step();
    checkOutput("bp_next_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
    consume("bp");

    // ---- Reset in the middle of ACCESS ----
    a_pready = 1'b0;
    applyStimulus(1'b0, 8'h33, 32'h0, 2'b00, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checkOutput("mr_in_access", 32'(a_penable), 32'd1);
    a_prst_n = 1'b0;
    #1;
    checkOutput("mr_psel", 32'(a_psel), 32'd0);
    checkOutput("mr_penable", 32'(a_penable), 32'd0);
    checkOutput("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mr_paddr", 32'(a_paddr), 32'd0);
    step();
    a_prst_n = 1'b1;
    a_pready = 1'b1;
    step();
    checkOutput("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("mr_no_stale_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("mr_no_psel", 32'(a_psel), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
